vga_tile_row_prefetch: RTL and testbench

Sits between shared main memory and the tile bit generator in the VGA path. For each superpixel row (20x15 grid), it fetches that row's tile/picture numbers from memory into a double-buffered line store ahead of display. The display side then reads picture numbers by superpixel column with fixed 1-cycle latency and never touches memory during active video. Memory access uses a req/grant handshake so the block can share the port with the CPU.

---
 rtl/vga_tile_row_prefetch.sv | 158 +++++++++++++++
 tb/tb_vga_tile_row_prefetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_row_prefetch.sv
// Prefetches one superpixel row of picture numbers into a double-buffered line store.
// Optional build macro VGA_PREFETCH_STATS_EN enables the saturating underrun counter.
module vga_tile_row_prefetch #(
  parameter int TILES_PER_ROW = 20,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int PIC_W         = 9,
  parameter int RD_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [3:0]        row_idx,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] row_length,
  input  logic              swap,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [4:0]        rd_col,
  output logic [PIC_W-1:0]  rd_pic,
  output logic              busy,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);
  localparam int COL_W = $clog2(TILES_PER_ROW);
  localparam int CNT_W = $clog2(TILES_PER_ROW + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TILES_PER_ROW);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(TILES_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    issueCnt;
  logic [CNT_W-1:0]    rcvCnt;
  logic                fillBank;
  logic                dispBank;
  logic [1:0]          bankVld;
  logic [1:0]          vldNext;
  logic                underrunHit;
  logic                retVld_p [RD_LAT];
  logic [COL_W-1:0]    retCol_p [RD_LAT];
  logic [PIC_W-1:0]    bankMem  [2][TILES_PER_ROW];
  logic [ADDR_W-1:0]   rowBase;
  logic                accept;
  logic                retHit;
  logic [COL_W-1:0]    retCol;
  logic                complete;
  logic                unusedRdataHi;

  assign rowBase       = start_addr + ADDR_W'(row_idx) * row_length;
  assign accept        = mem_req && mem_gnt;
  assign retHit        = retVld_p[RD_LAT-1];
  assign retCol        = retCol_p[RD_LAT-1];
  assign complete      = (state == DRAIN) && (rcvCnt == LAST);
  assign unusedRdataHi = ^mem_rdata[DATA_W-1:PIC_W];

  // Completion lands before the swap so a same-cycle swap sees the finished bank.
  always_comb begin
    vldNext     = bankVld;
    underrunHit = 1'b0;
    if (complete)
      vldNext[fillBank] = 1'b1;
    if (state == IDLE && fetch_start)
      vldNext[!dispBank] = 1'b0;
    if (swap) begin
      underrunHit        = !vldNext[!dispBank];
      vldNext[dispBank]  = 1'b0;
    end
  end

  // Request/issue stage, return-tag stage p0..p(RD_LAT-1), registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      dispBank <= 1'b0;
      fillBank <= 1'b0;
      bankVld  <= '0;
      issueCnt <= '0;
      rcvCnt   <= '0;
      rd_pic   <= '0;
      for (int i = 0; i < RD_LAT; i++)
        retVld_p[i] <= 1'b0;
    end else begin
      bankVld <= vldNext;
      if (swap)
        dispBank <= !dispBank;
      if (underrunHit)
        underrun <= 1'b1;
      retVld_p[0] <= accept;
      for (int i = 1; i < RD_LAT; i++)
        retVld_p[i] <= retVld_p[i-1];
      if (retHit)
        rcvCnt <= rcvCnt + 1'b1;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            fillBank <= !dispBank;
            mem_req  <= 1'b1;
            mem_addr <= rowBase;
            issueCnt <= '0;
            rcvCnt   <= '0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            issueCnt <= issueCnt + 1'b1;
            if (issueCnt == LAST_M1) begin
              mem_req <= 1'b0;
              state   <= DRAIN;
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (complete) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (32'(rd_col) < TILES_PER_ROW && bankVld[dispBank])
        rd_pic <= bankMem[dispBank][rd_col[COL_W-1:0]];
      else
        rd_pic <= '0;
    end
  end

  // Datapath side of the return stages: column tags and bank writes
  always_ff @(posedge clk) begin
    retCol_p[0] <= issueCnt[COL_W-1:0];
    for (int i = 1; i < RD_LAT; i++)
      retCol_p[i] <= retCol_p[i-1];
    if (retHit && !rst)
      bankMem[fillBank][retCol] <= mem_rdata[PIC_W-1:0];
  end

`ifdef VGA_PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun_cnt <= '0;
    else if (underrunHit && underrun_cnt != 8'hFF)
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_tile_row_prefetch.sv
// Directed bench for vga_tile_row_prefetch: two instances, RD_LAT=1 (A) and RD_LAT=3 (B).
module tb_vga_tile_row_prefetch;
  logic        clk = 1'b0;
  logic        rst, fetch_start, swap, mem_gnt, logClr;
  logic [3:0]  row_idx;
  logic [15:0] start_addr, row_length;
  logic [4:0]  rd_col;
  logic        reqA, busyA, urA, reqB, busyB, urB;
  logic [15:0] addrA, addrB, rdataA, rdataB;
  logic [8:0]  picA, picB;
  logic [7:0]  ucA, ucB;
  logic [15:0] pa0;
  logic [15:0] pb [3];
  logic [15:0] accLog [64];
  int          accN;
  int          errs = 0;
  int          checks = 0;

`ifdef VGA_PREFETCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  always #5 clk = ~clk;

  vga_tile_row_prefetch #(.RD_LAT(1)) dutA (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .row_idx(row_idx),
    .start_addr(start_addr), .row_length(row_length), .swap(swap),
    .mem_req(reqA), .mem_addr(addrA), .mem_gnt(mem_gnt), .mem_rdata(rdataA),
    .rd_col(rd_col), .rd_pic(picA), .busy(busyA), .underrun(urA), .underrun_cnt(ucA));

  vga_tile_row_prefetch #(.RD_LAT(3)) dutB (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .row_idx(row_idx),
    .start_addr(start_addr), .row_length(row_length), .swap(swap),
    .mem_req(reqB), .mem_addr(addrB), .mem_gnt(mem_gnt), .mem_rdata(rdataB),
    .rd_col(rd_col), .rd_pic(picB), .busy(busyB), .underrun(urB), .underrun_cnt(ucB));

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd3 + 16'h0100) ^ 16'hA000;
  endfunction

  function automatic logic [8:0] picOf(input logic [15:0] a);
    logic [15:0] w;
    w = memWord(a);
    return w[8:0];
  endfunction

  // Memory models: data for an accepted address appears RD_LAT cycles later
  always @(posedge clk) begin
    if (reqA && mem_gnt) pa0 <= addrA;
    pb[0] <= (reqB && mem_gnt) ? addrB : 16'h7777;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rdataA = memWord(pa0);
  assign rdataB = memWord(pb[2]);

  always @(posedge clk) begin
    if (logClr) accN = 0;
    else if (reqA && mem_gnt) begin
      if (accN < 64) accLog[accN] = addrA;
      accN++;
    end
  end

  typedef struct {
    logic [4:0] col;
    logic [8:0] exp;
  } rdVec_t;
  rdVec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic readChk(input string name, input logic [4:0] col, input logic [8:0] exp, input bit both);
    rd_col = col;
    tick;
    chk(name, 32'(picA), 32'(exp));
    if (both) chk({name, "_B"}, 32'(picB), 32'(exp));
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n;
    n = 0;
    while ((busyA || busyB) && n < maxCyc) begin
      tick;
      n++;
    end
    chk(name, 32'(busyA | busyB), 0);
  endtask

  task automatic startFetch(input logic [15:0] sa, input logic [15:0] len, input logic [3:0] row);
    start_addr  = sa;
    row_length  = len;
    row_idx     = row;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
  endtask

  task automatic pulseSwap;
    swap = 1'b1;
    tick;
    swap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int c = 0; c < 20; c++) vecs[c] = '{5'(c), picOf(16'(31 + c))};
    vecs[20] = '{5'd20, 9'd0};
    vecs[21] = '{5'd25, 9'd0};
    vecs[22] = '{5'd31, 9'd0};

    rst = 1'b1; fetch_start = 1'b0; swap = 1'b0; mem_gnt = 1'b1; logClr = 1'b1;
    row_idx = '0; start_addr = '0; row_length = '0; rd_col = '0;
    repeat (3) tick;
    chk("rst_req", 32'(reqA), 0);
    chk("rst_addr", 32'(addrA), 0);
    chk("rst_busy", 32'(busyA | busyB), 0);
    chk("rst_pic", 32'(picA), 0);
    chk("rst_underrun", 32'(urA), 0);
    chk("rst_ucnt", 32'(ucA), 0);
    rst = 1'b0; logClr = 1'b0;
    tick;

    // Basic fill: base = 1 + 2*15 = 31, gnt always high
    startFetch(16'd1, 16'd15, 4'd2);
    chk("t1_busy_rise", 32'(busyA), 1);
    for (int i = 0; i < 20; i++) begin
      chk("t1_addr", 32'(addrA), 32'(31 + i));
      chk("t1_req", 32'(reqA), 1);
      tick;
    end
    chk("t1_req_drop", 32'(reqA), 0);
    chk("t1_busy_c21", 32'(busyA), 1);
    tick;
    chk("t1_busy_c22", 32'(busyA), 1);
    tick;
    chk("t1_busy_fall", 32'(busyA), 0);
    waitIdle("t1_idle", 20);
    readChk("t1_pre_swap", 5'd0, 9'd0, 1'b1);
    pulseSwap;
    chk("t1_underrun", 32'(urA | urB), 0);
    for (int v = 0; v < 23; v++) readChk("t1_rd", vecs[v].col, vecs[v].exp, 1'b1);

    // Stalled grant: 1 cycle on, 2 off; base = 0x100 + 3*20 = 0x13C
    logClr = 1'b1; tick; logClr = 1'b0;
    startFetch(16'h0100, 16'd20, 4'd3);
    bad = 0;
    for (int k = 0; k < 200 && (busyA || busyB); k++) begin
      mem_gnt = (k % 3 == 0);
      if (reqA && addrA !== 16'(16'h013C + accN)) bad++;
      tick;
    end
    mem_gnt = 1'b1;
    chk("t2_idle", 32'(busyA | busyB), 0);
    chk("t2_stall_addr", 32'(bad), 0);
    chk("t2_accepts", 32'(accN), 20);
    bad = 0;
    for (int i = 0; i < 20; i++) if (accLog[i] !== 16'(16'h013C + i)) bad++;
    chk("t2_addr_log", 32'(bad), 0);
    pulseSwap;
    readChk("t2_rd5", 5'd5, picOf(16'h0141), 1'b1);
    readChk("t2_rd19", 5'd19, picOf(16'h014F), 1'b1);
    chk("t2_underrun", 32'(urA), 0);

    // Swap in the exact completion cycle of A: base = 0x300 + 0x10 = 0x310
    startFetch(16'h0300, 16'h0010, 4'd1);
    repeat (21) tick;
    chk("t4_busy_complete_cyc", 32'(busyA), 1);
    pulseSwap;
    chk("t4_busy_fall", 32'(busyA), 0);
    chk("t4_underrun", 32'(urA), 0);
    waitIdle("t4_idle", 20);
    readChk("t4_rd0", 5'd0, picOf(16'h0310), 1'b0);
    readChk("t4_rd7", 5'd7, picOf(16'h0317), 1'b0);

    // Early swap during ISSUE, then a second early swap
    startFetch(16'h0200, 16'd0, 4'd0);
    repeat (3) tick;
    pulseSwap;
    chk("t3_underrun", 32'(urA), 1);
    chk("t3_ucnt1", 32'(ucA), 32'(STATS));
    readChk("t3_rd0_blank", 5'd0, 9'd0, 1'b0);
    readChk("t3_rd5_blank", 5'd5, 9'd0, 1'b0);
    waitIdle("t3_idle", 40);
    readChk("t3_rd2_filled", 5'd2, picOf(16'h0202), 1'b1);
    pulseSwap;
    chk("t3_ucnt2", 32'(ucA), 32'(2 * STATS));
    chk("t3_underrun_sticky", 32'(urA), 1);
    readChk("t3_rd2_blank", 5'd2, 9'd0, 1'b0);

    // Address wrap at 0xFFFF
    startFetch(16'hFFF0, 16'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      chk("t5_addr", 32'(addrA), 32'(16'(16'hFFF0 + i)));
      tick;
    end
    waitIdle("t5_idle", 20);
    pulseSwap;
    chk("t5_ucnt_hold", 32'(ucA), 32'(2 * STATS));
    readChk("t5_rd0", 5'd0, picOf(16'hFFF0), 1'b1);
    readChk("t5_rd15", 5'd15, picOf(16'hFFFF), 1'b0);
    readChk("t5_rd16", 5'd16, picOf(16'h0000), 1'b0);
    readChk("t5_rd19", 5'd19, picOf(16'h0003), 1'b1);
    readChk("t5_rd25", 5'd25, 9'd0, 1'b1);

    // Reset mid-ISSUE, then refetch while stale RD_LAT=3 data is still returning
    startFetch(16'h0400, 16'd0, 4'd0);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_req", 32'(reqA | reqB), 0);
    chk("t6_busy", 32'(busyA | busyB), 0);
    chk("t6_pic", 32'(picA | picB), 0);
    chk("t6_underrun", 32'(urA), 0);
    chk("t6_ucnt", 32'(ucA), 0);
    rd_col = 5'd0;
    startFetch(16'h0500, 16'd0, 4'd0);
    chk("t6_pic_after_rst", 32'(picA | picB), 0);
    repeat (23) tick;
    chk("t6_busyB_c24", 32'(busyB), 1);
    tick;
    chk("t6_busyB_fall", 32'(busyB), 0);
    pulseSwap;
    chk("t6_underrunB", 32'(urB | urA), 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      rd_col = 5'(c);
      tick;
      if (picB !== picOf(16'(16'h0500 + c)) || picA !== picOf(16'(16'h0500 + c))) bad++;
    end
    chk("t6_refill_data", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
